// File: rtl/cont_modn_updn.sv
// Modulo-N up/down counter with synchronous load, combinational terminal count
// and a registered wrap pulse. Define CONT_SATURATE_EN to saturate at the limits instead of wrapping.
module cont_modn_updn #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             Y,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Wrap
);

  localparam longint unsigned ModLimit = 64'(1) << WIDTH;

  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || longint'(MODULUS) > ModLimit) begin : g_bad_param
    $fatal(1, "cont_modn_updn: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] QMax  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] QZero = '0;
  localparam logic [WIDTH-1:0] QOne  = WIDTH'(1);
  localparam logic [WIDTH:0]   ModW  = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic             at_max, at_min;
  logic             tc;

  assign at_max = (q_q == QMax);
  assign at_min = (q_q == QZero);

  // Load always wins, so it masks the terminal count even at a limit.
  assign tc = En & ~Load & ((Y & at_max) | (~Y & at_min));

  always_comb begin
    q_d    = q_q;
    wrap_d = tc;
    if (Load) begin
      if ({1'b0, D} >= ModW) begin
        q_d = QMax;
      end else begin
        q_d = D;
      end
    end else if (En) begin
      if (Y) begin
        if (at_max) begin
`ifdef CONT_SATURATE_EN
          q_d = QMax;
`else
          q_d = QZero;
`endif
        end else begin
          q_d = q_q + QOne;
        end
      end else begin
        if (at_min) begin
`ifdef CONT_SATURATE_EN
          q_d = QZero;
`else
          q_d = QMax;
`endif
        end else begin
          q_d = q_q - QOne;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q_q    <= QZero;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Tc   = tc;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_cont_modn_updn.sv
// Randomized and directed checks of cont_modn_updn (MODULUS 16 and 10 instances)
// against an arithmetic reference model.
module tb_cont_modn_updn;

`ifdef CONT_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en, y, load;
  logic [3:0] d;
  logic [3:0] q16, q10;
  logic       tc16, tc10, wrap16, wrap10;

  int n_checks;
  int n_errors;
  int m16, m10;
  bit mw16, mw10;

  cont_modn_updn u_dut16 (
    .Clk  (clk),
    .Rst_n(rst_n),
    .En   (en),
    .Y    (y),
    .Load (load),
    .D    (d),
    .Q    (q16),
    .Tc   (tc16),
    .Wrap (wrap16)
  );

  cont_modn_updn #(
    .WIDTH  (4),
    .MODULUS(10)
  ) u_dut10 (
    .Clk  (clk),
    .Rst_n(rst_n),
    .En   (en),
    .Y    (y),
    .Load (load),
    .D    (d),
    .Q    (q10),
    .Tc   (tc10),
    .Wrap (wrap10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_q(int q, int m, bit e, bit up, bit ld, int dv);
    if (ld) return (dv > m - 1) ? m - 1 : dv;
    if (!e) return q;
    if (up) return (q == m - 1) ? (Sat ? q : 0) : q + 1;
    return (q == 0) ? (Sat ? 0 : m - 1) : q - 1;
  endfunction

  function automatic bit tc_of(int q, int m, bit e, bit up, bit ld);
    return e && !ld && (up ? (q == m - 1) : (q == 0));
  endfunction

  // One clock: check Tc before the edge, advance the model, check Q/Wrap after it.
  task automatic cycle();
    bit t16, t10;
    #1;
    t16 = tc_of(m16, 16, en, y, load);
    t10 = tc_of(m10, 10, en, y, load);
    check_eq("tc16", int'(tc16), int'(t16));
    check_eq("tc10", int'(tc10), int'(t10));
    @(posedge clk);
    m16  = next_q(m16, 16, en, y, load, int'(d));
    m10  = next_q(m10, 10, en, y, load, int'(d));
    mw16 = t16;
    mw10 = t10;
    #1;
    check_eq("q16", int'(q16), m16);
    check_eq("q10", int'(q10), m10);
    check_eq("wrap16", int'(wrap16), int'(mw16));
    check_eq("wrap10", int'(wrap10), int'(mw10));
  endtask

  // Asynchronous reset pulse placed between edges; called just after an edge.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_q16", int'(q16), 0);
    check_eq("rst_q10", int'(q10), 0);
    check_eq("rst_wrap16", int'(wrap16), 0);
    check_eq("rst_wrap10", int'(wrap10), 0);
    #2 rst_n = 1'b1;
    m16  = 0;
    m10  = 0;
    mw16 = 1'b0;
    mw10 = 1'b0;
  endtask

  task automatic load_both(input int v);
    load = 1'b1;
    en   = 1'b0;
    d    = 4'(v);
    cycle();
    load = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m16 = 0; m10 = 0; mw16 = 1'b0; mw10 = 1'b0;
    rst_n = 1'b0;
    en = 1'b1; y = 1'b0; load = 1'b0; d = '0;

    // Reset held across edges: Q and Wrap stay 0, Tc still evaluates from Q=0.
    #12;
    check_eq("reset_q16", int'(q16), 0);
    check_eq("reset_wrap16", int'(wrap16), 0);
    check_eq("reset_tc16", int'(tc16), 1);
    y = 1'b1;
    #1;
    check_eq("reset_tc16_up", int'(tc16), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m16 = int'(q16 == 4'd1) ? 1 : -1;
    m10 = 1;
    check_eq("first_edge_q16", int'(q16), 1);

    // Count up 17 edges from zero: wraps once at 15 -> 0.
    pulse_reset();
    en = 1'b1; y = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cycle();
      check_eq("up17_q", int'(q16), Sat ? ((i + 1 > 15) ? 15 : i + 1) : (i + 1) % 16);
      check_eq("up17_wrap", int'(wrap16), int'(i == 15 || (Sat && i == 16)));
    end

    // Count down from zero: Tc up front, then 15, 14 with one Wrap pulse.
    pulse_reset();
    en = 1'b1; y = 1'b0;
    #1;
    check_eq("down_tc_at0", int'(tc16), 1);
    cycle();
    check_eq("down_q1", int'(q16), Sat ? 0 : 15);
    check_eq("down_wrap1", int'(wrap16), 1);
    if (!Sat) begin
      cycle();
      check_eq("down_q2", int'(q16), 14);
      check_eq("down_wrap2", int'(wrap16), 0);
    end

    // MODULUS 10: clamped load, wrap from 9, and a load of 9 yields no Wrap.
    load_both(12);
    check_eq("m10_load12", int'(q10), 9);
    check_eq("m10_load_wrap", int'(wrap10), 0);
    en = 1'b1; y = 1'b1;
    cycle();
    check_eq("m10_up_q", int'(q10), Sat ? 9 : 0);
    check_eq("m10_up_wrap", int'(wrap10), 1);
    load_both(9);
    check_eq("m10_load9_wrap", int'(wrap10), 0);
    check_eq("m10_load9_q", int'(q10), 9);

    // At the top limit for three enabled up edges.
    load_both(15);
    en = 1'b1; y = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("top_tc", int'(tc16), (Sat || i == 0) ? 1 : 0);
      cycle();
      check_eq("top_q", int'(q16), Sat ? 15 : i);
      check_eq("top_wrap", int'(wrap16), (Sat || i == 0) ? 1 : 0);
    end

    // Reset mid-count from 7, then the next edge counts from 0.
    load_both(7);
    en = 1'b1; y = 1'b1;
    pulse_reset();
    cycle();
    check_eq("post_reset_q16", int'(q16), 1);
    check_eq("post_reset_wrap16", int'(wrap16), 0);

    // Reset pending over a load: the load is discarded.
    load = 1'b1; d = 4'd11;
    pulse_reset();
    load = 1'b0; en = 1'b0;
    cycle();
    check_eq("load_discard_q16", int'(q16), 0);

    // Direction reversal every edge from 5: 6, 5, 6, 5.
    load_both(5);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      y = (i % 2 == 0);
      cycle();
      check_eq("toggle_q16", int'(q16), (i % 2 == 0) ? 6 : 5);
    end

    // Hold: Wrap drops after a wrap edge followed by En=0.
    load_both(15);
    en = 1'b1; y = 1'b1;
    cycle();
    en = 1'b0;
    cycle();
    check_eq("hold_wrap16", int'(wrap16), 0);
    check_eq("hold_q16", int'(q16), Sat ? 15 : 0);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      y    = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      d    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) pulse_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cont_modn_updn.md
CONT_MODN_UPDN -- requirements
Module: cont_modn_updn

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter register width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 16, meaning count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH, and any other value SHALL halt elaboration.
REQ-003 Port Clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 Port Rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 Port En, input, 1, meaning count enable.
REQ-006 Port Y, input, 1, meaning direction: 1 = up, 0 = down.
REQ-007 Port Load, input, 1, meaning synchronous parallel load.
REQ-008 Port D, input, WIDTH, meaning load value.
REQ-009 Port Q, output, WIDTH, meaning current count, driven directly from the register.
REQ-010 Port Tc, output, 1, meaning combinational terminal count.
REQ-011 Port Wrap, output, 1, meaning registered one-cycle pulse flagging a wrap or saturation event.

Function
REQ-012 Priority per rising edge SHALL be Load, then En, then hold.
REQ-013 Load=1 SHALL set Q to D when D <= MODULUS-1, and SHALL set Q to MODULUS-1 when D >= MODULUS, regardless of En and Y.
REQ-014 Load=0, En=1, Y=1 SHALL set Q to Q+1; at Q=MODULUS-1 the next value SHALL follow REQ-022/REQ-023.
REQ-015 Load=0, En=1, Y=0 SHALL set Q to Q-1; at Q=0 the next value SHALL follow REQ-022/REQ-023.
REQ-016 Load=0, En=0 SHALL hold Q unchanged and SHALL drive Wrap=0 on the next cycle.
REQ-017 Tc SHALL equal En AND NOT Load AND ((Y AND Q==MODULUS-1) OR (NOT Y AND Q==0)), with zero latency.
REQ-018 Wrap SHALL be 1 for exactly the one cycle following an edge at which Tc was 1, and 0 otherwise.
REQ-019 Load SHALL never produce Wrap=1, including a load of 0 or MODULUS-1.
REQ-020 A change of Y between cycles SHALL reverse the count on the next enabled edge, with no dead cycle.
REQ-021 Q SHALL never leave the range 0..MODULUS-1 after reset or load.

Configuration
REQ-022 With macro CONT_SATURATE_EN undefined, count SHALL wrap: up from MODULUS-1 to 0, and down from 0 to MODULUS-1.
REQ-023 With CONT_SATURATE_EN defined, count SHALL saturate: Q SHALL hold at MODULUS-1 counting up and hold at 0 counting down, while Tc and Wrap SHALL still assert per REQ-017/REQ-018 on every enabled edge at the limit.

Reset
REQ-024 Rst_n=0 SHALL immediately force Q=0 and Wrap=0, independent of Clk.
REQ-025 Tc SHALL evaluate per REQ-017 during reset, using Q=0.
REQ-026 Rst_n asserted mid-count or mid-load SHALL discard the pending update; the first edge after deassertion SHALL evaluate normally from Q=0.

Verification
REQ-027 The bench SHALL cover this case with defaults: reset, then En=1, Y=1 for 17 edges -> Q runs 1..15, 0, 1; Wrap=1 only in the cycle after Q=15->0.
REQ-028 The bench SHALL cover this case with defaults: reset, then En=1, Y=0 for 2 edges -> Q=15, then 14; Tc=1 while Q=0 and En=1; Wrap pulses once.
REQ-029 The bench SHALL cover this case with WIDTH=4, MODULUS=10: Load=1, D=12 -> Q=9; then Y=1, En=1, 1 edge -> Q=0 with Wrap=1; Load=1, D=9 -> Wrap=0.
REQ-030 The bench SHALL cover this case with CONT_SATURATE_EN defined and defaults: Q=15, Y=1, En=1 for 3 edges -> Q stays 15; Tc=1 throughout; Wrap=1 for 3 cycles.
REQ-031 The bench SHALL cover this case: Q=7, counting up, Rst_n pulsed low for 3 ns between edges -> Q=0 immediately, Wrap=0; next edge -> Q=1.
REQ-032 The bench SHALL cover this case: Q=5, En=1, and Y toggled every cycle for 4 edges -> Q sequence 6, 5, 6, 5.
